// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - PC sequencing controller: fetch, branch/jump/JR resolve, exception vectoring.
// Optional exception path enabled by defining PC_CTRL_EXC_EN.
module pc_ctrl #(
  parameter int EXC_LAT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       br_req,
  input  logic       br_cond,
  input  logic       jmp_req,
  input  logic       jr_req,
  input  logic       exc_req,
  output logic [2:0] PcSrc,
  output logic       PcWrite,
  output logic       EPCWrite,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_DEC = 3'd2,
    S_RESOLVE  = 3'd3
`ifdef PC_CTRL_EXC_EN
    ,
    S_EXC_SAVE = 3'd4,
    S_EXC_LOAD = 3'd5,
    S_EXC_JUMP = 3'd6
`endif
  } state_t;

  localparam logic [2:0] SEL_PC4 = 3'b000;
  localparam logic [2:0] SEL_BR  = 3'b001;
  localparam logic [2:0] SEL_JMP = 3'b010;
  localparam logic [2:0] SEL_REG = 3'b011;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_sel;
  logic [2:0] w_sel_next;

`ifdef PC_CTRL_EXC_EN
  localparam logic [2:0] SEL_VEC  = 3'b100;
  localparam logic [2:0] LAT_LAST = 3'(EXC_LAT - 1);
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_next;
`else
  localparam logic [2:0] LAT_UNUSED = 3'(EXC_LAT);
  logic w_unused_exc;
  assign w_unused_exc = exc_req ^ (|LAT_UNUSED);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sel   <= SEL_PC4;
`ifdef PC_CTRL_EXC_EN
      r_cnt   <= 3'd0;
`endif
    end else begin
      r_state <= w_next;
      r_sel   <= w_sel_next;
`ifdef PC_CTRL_EXC_EN
      r_cnt   <= w_cnt_next;
`endif
    end
  end

  always_comb begin
    w_next     = r_state;
    w_sel_next = r_sel;
    PcSrc      = SEL_PC4;
    PcWrite    = 1'b0;
    EPCWrite   = 1'b0;
    busy       = (r_state != S_IDLE);
`ifdef PC_CTRL_EXC_EN
    w_cnt_next = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (step) w_next = S_FETCH;
      end
      S_FETCH: begin
        PcWrite = 1'b1;
        w_next  = S_WAIT_DEC;
      end
      S_WAIT_DEC: begin
        w_next = S_IDLE;
        if (jr_req) begin
          w_sel_next = SEL_REG;
          w_next     = S_RESOLVE;
        end else if (jmp_req) begin
          w_sel_next = SEL_JMP;
          w_next     = S_RESOLVE;
        end else if (br_req && br_cond) begin
          w_sel_next = SEL_BR;
          w_next     = S_RESOLVE;
        end
`ifdef PC_CTRL_EXC_EN
        // Exception outranks every redirect request.
        if (exc_req) w_next = S_EXC_SAVE;
`endif
      end
      S_RESOLVE: begin
        PcSrc   = r_sel;
        PcWrite = 1'b1;
        w_next  = S_IDLE;
`ifdef PC_CTRL_EXC_EN
        // A late exception kills the redirect write in the same cycle.
        if (exc_req) begin
          PcWrite = 1'b0;
          w_next  = S_EXC_SAVE;
        end
`endif
      end
`ifdef PC_CTRL_EXC_EN
      S_EXC_SAVE: begin
        EPCWrite   = 1'b1;
        w_cnt_next = 3'd0;
        w_next     = S_EXC_LOAD;
      end
      S_EXC_LOAD: begin
        if (r_cnt == LAT_LAST) w_next = S_EXC_JUMP;
        else w_cnt_next = r_cnt + 3'd1;
      end
      S_EXC_JUMP: begin
        PcSrc   = SEL_VEC;
        PcWrite = 1'b1;
        w_next  = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

endmodule
